// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX operand forwarding selects and load-use stall control
// Shadows ID/EX, EX/MEM, MEM/WB and RET destination info to steer the EX operand muxes.
module fwd_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic [REG_W-1:0] id_dst_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             flush_i,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic             stall_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             idex_bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic [REG_W-1:0] idex_rs_q, idex_rs_d;
    logic [REG_W-1:0] idex_rt_q, idex_rt_d;
    logic [REG_W-1:0] idex_dst_q, idex_dst_d;
    logic             idex_rw_q, idex_rw_d;
    logic             idex_mr_q, idex_mr_d;
    logic [REG_W-1:0] exm_dst_q, exm_dst_d;
    logic             exm_rw_q, exm_rw_d;
    logic [REG_W-1:0] mwb_dst_q, mwb_dst_d;
    logic             mwb_rw_q, mwb_rw_d;
    logic [REG_W-1:0] ret_dst_q, ret_dst_d;
    logic             ret_rw_q, ret_rw_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic hazard;
    logic stall;
    logic bubble;

    // Nearest producer wins; register 0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] e_dst, input logic e_rw,
        input logic [REG_W-1:0] m_dst, input logic m_rw,
        input logic [REG_W-1:0] r_dst, input logic r_rw
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (e_rw && (e_dst != '0) && (e_dst == src)) begin
            sel = 2'b10;
        end else if (m_rw && (m_dst != '0) && (m_dst == src)) begin
            sel = 2'b01;
        end else if (r_rw && (r_dst != '0) && (r_dst == src)) begin
            sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        hazard = id_valid_i & idex_mr_q & idex_rw_q & (idex_dst_q != '0)
               & ((idex_dst_q == id_rs_i) | (idex_dst_q == id_rt_i));
        stall  = hazard & ~flush_i;
        // Gated by reset so the bubble request is quiet while reset is held.
        bubble = rst_i & (stall | flush_i | ~id_valid_i);
    end

    always_comb begin
        idex_rs_d  = id_rs_i;
        idex_rt_d  = id_rt_i;
        idex_dst_d = id_dst_i;
        idex_rw_d  = id_regwrite_i;
        idex_mr_d  = id_memread_i;
        if (bubble) begin
            idex_rs_d  = '0;
            idex_rt_d  = '0;
            idex_dst_d = '0;
            idex_rw_d  = 1'b0;
            idex_mr_d  = 1'b0;
        end
        exm_dst_d = idex_dst_q;
        exm_rw_d  = idex_rw_q;
        mwb_dst_d = exm_dst_q;
        mwb_rw_d  = exm_rw_q;
        ret_dst_d = mwb_dst_q;
        ret_rw_d  = mwb_rw_q;
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_rs_q   <= '0;
            idex_rt_q   <= '0;
            idex_dst_q  <= '0;
            idex_rw_q   <= 1'b0;
            idex_mr_q   <= 1'b0;
            exm_dst_q   <= '0;
            exm_rw_q    <= 1'b0;
            mwb_dst_q   <= '0;
            mwb_rw_q    <= 1'b0;
            ret_dst_q   <= '0;
            ret_rw_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            idex_rs_q   <= idex_rs_d;
            idex_rt_q   <= idex_rt_d;
            idex_dst_q  <= idex_dst_d;
            idex_rw_q   <= idex_rw_d;
            idex_mr_q   <= idex_mr_d;
            exm_dst_q   <= exm_dst_d;
            exm_rw_q    <= exm_rw_d;
            mwb_dst_q   <= mwb_dst_d;
            mwb_rw_q    <= mwb_rw_d;
            ret_dst_q   <= ret_dst_d;
            ret_rw_q    <= ret_rw_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        fwd_a_sel_o   = fwd_sel(idex_rs_q, exm_dst_q, exm_rw_q, mwb_dst_q, mwb_rw_q,
                                ret_dst_q, ret_rw_q);
        fwd_b_sel_o   = fwd_sel(idex_rt_q, exm_dst_q, exm_rw_q, mwb_dst_q, mwb_rw_q,
                                ret_dst_q, ret_rw_q);
        stall_o       = stall;
        pc_write_o    = ~stall;
        ifid_write_o  = ~stall;
        idex_bubble_o = bubble;
        stall_cnt_o   = stall_cnt_q;
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - self-checking bench for fwd_hazard_ctrl
// Directed table, mid-run reset, random stimulus against a pipeline model, counter saturation.
module tb_fwd_hazard_ctrl;

    localparam int REG_W   = 5;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             id_valid_i;
    logic [REG_W-1:0] id_rs_i, id_rt_i, id_dst_i;
    logic             id_regwrite_i, id_memread_i, flush_i;
    logic [1:0]       fwd_a_sel_o, fwd_b_sel_o;
    logic             stall_o, pc_write_o, ifid_write_o, idex_bubble_o;
    logic [CNT_W-1:0] stall_cnt_o;

    fwd_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_dst_i(id_dst_i),
        .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i), .flush_i(flush_i),
        .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o), .stall_o(stall_o),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
        .idex_bubble_o(idex_bubble_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pipeline model: slot 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB, 3 = retired.
    typedef struct {
        logic [REG_W-1:0] rs, rt, dst;
        logic             rw, mr;
    } ins_t;

    ins_t pipe[4];
    int   m_cnt;

    function automatic int m_sel(input logic [REG_W-1:0] src);
        for (int k = 1; k < 4; k++) begin
            if (pipe[k].rw && pipe[k].dst != 0 && pipe[k].dst == src) begin
                case (k)
                    1:       return 2;
                    2:       return 1;
                    default: return 3;
                endcase
            end
        end
        return 0;
    endfunction

    function automatic int m_stall();
        int hz;
        hz = (id_valid_i && pipe[0].mr && pipe[0].rw && pipe[0].dst != 0 &&
              (pipe[0].dst == id_rs_i || pipe[0].dst == id_rt_i)) ? 1 : 0;
        return (hz == 1 && !flush_i) ? 1 : 0;
    endfunction

    function automatic int m_bubble();
        return (m_stall() == 1 || flush_i || !id_valid_i) ? 1 : 0;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 4; k++) pipe[k] = '{rs: 0, rt: 0, dst: 0, rw: 0, mr: 0};
        m_cnt = 0;
    endtask

    task automatic m_clock();
        if (m_stall() == 1 && m_cnt < CNT_MAX) m_cnt++;
        for (int k = 3; k > 0; k--) pipe[k] = pipe[k-1];
        if (m_bubble() == 1) pipe[0] = '{rs: 0, rt: 0, dst: 0, rw: 0, mr: 0};
        else pipe[0] = '{rs: id_rs_i, rt: id_rt_i, dst: id_dst_i,
                         rw: id_regwrite_i, mr: id_memread_i};
    endtask

    task automatic check_model(input string tag);
        int st;
        st = m_stall();
        chk({tag, "_a"}, int'(fwd_a_sel_o), m_sel(pipe[0].rs));
        chk({tag, "_b"}, int'(fwd_b_sel_o), m_sel(pipe[0].rt));
        chk({tag, "_stall"}, int'(stall_o), st);
        chk({tag, "_pcw"}, int'(pc_write_o), 1 - st);
        chk({tag, "_ifidw"}, int'(ifid_write_o), 1 - st);
        chk({tag, "_bub"}, int'(idex_bubble_o), m_bubble());
        chk({tag, "_cnt"}, int'(stall_cnt_o), m_cnt);
    endtask

    task automatic drive(input logic v, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                         input logic [REG_W-1:0] dst, input logic rw, input logic mr,
                         input logic fl);
        id_valid_i = v; id_rs_i = rs; id_rt_i = rt; id_dst_i = dst;
        id_regwrite_i = rw; id_memread_i = mr; flush_i = fl;
    endtask

    task automatic step(input string tag, input logic v, input logic [REG_W-1:0] rs,
                        input logic [REG_W-1:0] rt, input logic [REG_W-1:0] dst,
                        input logic rw, input logic mr, input logic fl, output int st);
        @(negedge clk);
        drive(v, rs, rt, dst, rw, mr, fl);
        #1;
        st = m_stall();
        check_model(tag);
        m_clock();
    endtask

    typedef struct {
        logic             v;
        logic [REG_W-1:0] rs, rt, dst;
        logic             rw, mr, fl;
        int               ea, eb, es, ebub, ecnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t ins_row(input int rs, input int rt, input int dst, input int mr,
                                     input int fl, input int ea, input int eb, input int es,
                                     input int ebub, input int ecnt);
        vec_t r;
        r.v = 1'b1; r.rs = REG_W'(rs); r.rt = REG_W'(rt); r.dst = REG_W'(dst);
        r.rw = 1'b1; r.mr = mr[0]; r.fl = fl[0];
        r.ea = ea; r.eb = eb; r.es = es; r.ebub = ebub; r.ecnt = ecnt;
        return r;
    endfunction

    function automatic vec_t nop_row(input int ea, input int eb, input int ecnt);
        vec_t r;
        r.v = 1'b0; r.rs = '0; r.rt = '0; r.dst = '0; r.rw = 1'b0; r.mr = 1'b0; r.fl = 1'b0;
        r.ea = ea; r.eb = eb; r.es = 0; r.ebub = 1; r.ecnt = ecnt;
        return r;
    endfunction

    task automatic nops(input int n, input int ecnt);
        for (int i = 0; i < n; i++) tbl.push_back(nop_row(0, 0, ecnt));
    endtask

    initial begin
        int st;
        logic             rv, rrw, rmr, rfl;
        logic [REG_W-1:0] rrs, rrt, rdst;

        // add $3,$1,$2 ; sub $5,$3,$4 -> A from EX/MEM
        tbl.push_back(ins_row(1, 2, 3, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(ins_row(3, 4, 5, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(nop_row(2, 0, 0));
        nops(3, 0);
        // add $3 ; nop ; nop ; or $6,$7,$3 -> B from retired
        tbl.push_back(ins_row(1, 2, 3, 0, 0, 0, 0, 0, 0, 0));
        nops(2, 0);
        tbl.push_back(ins_row(7, 3, 6, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(nop_row(0, 3, 0));
        nops(3, 0);
        // add $3 ; nop ; or -> B from MEM/WB
        tbl.push_back(ins_row(1, 2, 3, 0, 0, 0, 0, 0, 0, 0));
        nops(1, 0);
        tbl.push_back(ins_row(7, 3, 6, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(nop_row(0, 1, 0));
        nops(3, 0);
        // lw $2 ; add $4,$2,$2 -> one stall, re-presented add, both from MEM/WB
        tbl.push_back(ins_row(1, 0, 2, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(ins_row(2, 2, 4, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(ins_row(2, 2, 4, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(nop_row(1, 1, 1));
        nops(3, 1);
        // lw $2 ; dependent add with flush -> flush wins
        tbl.push_back(ins_row(1, 0, 2, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(ins_row(2, 2, 4, 0, 1, 0, 0, 0, 1, 1));
        nops(3, 1);
        // writer of $0 then reader of $0
        tbl.push_back(ins_row(1, 2, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(ins_row(0, 0, 5, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(nop_row(0, 0, 1));
        nops(3, 1);
        // addi $3 ; addi $3 ; add $8,$3,$3 -> nearest wins
        tbl.push_back(ins_row(1, 0, 3, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(ins_row(1, 0, 3, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(ins_row(3, 3, 8, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(nop_row(2, 2, 1));
        nops(3, 1);
        // add $3 ; add $4 ; add $9,$4,$3 -> A and B from different stages
        tbl.push_back(ins_row(1, 2, 3, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(ins_row(1, 2, 4, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(ins_row(4, 3, 9, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(nop_row(2, 1, 1));
        nops(3, 1);

        rst_i = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        m_reset();
        #12;
        chk("rst_a", int'(fwd_a_sel_o), 0);
        chk("rst_b", int'(fwd_b_sel_o), 0);
        chk("rst_stall", int'(stall_o), 0);
        chk("rst_bub", int'(idex_bubble_o), 0);
        chk("rst_pcw", int'(pc_write_o), 1);
        chk("rst_ifidw", int'(ifid_write_o), 1);
        chk("rst_cnt", int'(stall_cnt_o), 0);

        @(negedge clk);
        rst_i = 1'b1;
        drive(1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rel_bub", int'(idex_bubble_o), 0);
        chk("rel_stall", int'(stall_o), 0);
        chk("rel_cnt", int'(stall_cnt_o), 0);
        m_clock();

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].dst, tbl[i].rw, tbl[i].mr, tbl[i].fl);
            #1;
            chk($sformatf("tbl%0d_a", i), int'(fwd_a_sel_o), tbl[i].ea);
            chk($sformatf("tbl%0d_b", i), int'(fwd_b_sel_o), tbl[i].eb);
            chk($sformatf("tbl%0d_stall", i), int'(stall_o), tbl[i].es);
            chk($sformatf("tbl%0d_pcw", i), int'(pc_write_o), 1 - tbl[i].es);
            chk($sformatf("tbl%0d_ifidw", i), int'(ifid_write_o), 1 - tbl[i].es);
            chk($sformatf("tbl%0d_bub", i), int'(idex_bubble_o), tbl[i].ebub);
            chk($sformatf("tbl%0d_cnt", i), int'(stall_cnt_o), tbl[i].ecnt);
            m_clock();
        end

        // Mid-run reset with a forward and a stall pending
        step("pre0", 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, st);
        step("pre1", 1'b1, 5'd3, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, st);
        @(negedge clk);
        drive(1'b1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
        #1;
        check_model("pre2");
        chk("pre2_a_fwd", int'(fwd_a_sel_o), 2);
        chk("pre2_stall_set", int'(stall_o), 1);
        rst_i = 1'b0;
        #1;
        m_reset();
        chk("mrst_a", int'(fwd_a_sel_o), 0);
        chk("mrst_b", int'(fwd_b_sel_o), 0);
        chk("mrst_stall", int'(stall_o), 0);
        chk("mrst_bub", int'(idex_bubble_o), 0);
        chk("mrst_pcw", int'(pc_write_o), 1);
        chk("mrst_ifidw", int'(ifid_write_o), 1);
        chk("mrst_cnt", int'(stall_cnt_o), 0);
        @(posedge clk);
        #1;
        chk("mrst_hold_cnt", int'(stall_cnt_o), 0);
        @(negedge clk);
        rst_i = 1'b1;

        // Random traffic; a stalled instruction is re-presented the next cycle
        st = 0;
        rv = 0; rrs = '0; rrt = '0; rdst = '0; rrw = 0; rmr = 0;
        for (int i = 0; i < 1500; i++) begin
            if (st == 0) begin
                rv   = ($urandom_range(0, 99) < 85);
                rrs  = REG_W'($urandom_range(0, 3));
                rrt  = REG_W'($urandom_range(0, 3));
                rdst = REG_W'($urandom_range(0, 3));
                rrw  = ($urandom_range(0, 99) < 80);
                rmr  = ($urandom_range(0, 99) < 30);
            end
            rfl = ($urandom_range(0, 99) < 8);
            step("rnd", rv, rrs, rrt, rdst, rrw, rmr, rfl, st);
        end

        // Back-to-back load-use pairs to drive the counter past all-ones
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            step("sat_lw", 1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, st);
            step("sat_use", 1'b1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, st);
        end
        @(negedge clk);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("sat_cnt", int'(stall_cnt_o), CNT_MAX);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
